// File: rtl/frame_serializer.sv
// Frame serializer: captures a 16-bit frame plus tag, emits it as nibble beats with a last marker.
// Optional FRAME_SER_PARITY_EN adds a fifth XOR-parity beat.
module frame_serializer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:3][3:4][4:1]  frame,
   input  logic [2:3]            tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_data,
   output logic [1:0]            out_tag,
   output logic                  out_last,
   output logic [CNT_W-1:0]      frame_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef FRAME_SER_PARITY_EN
   localparam logic [1:0] S_PAR   = 2'd2;
`endif

   logic [1:0]       r_state;
   logic [1:0]       r_beat;
   logic [15:0]      r_frame;
   logic [1:0]       r_tag;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [3:0]       r_out_data;
   logic             r_out_last;

   logic [1:0]  w_state_nxt;
   logic [1:0]  w_beat_nxt;
   logic        w_cap;
   logic        w_done;
   logic        w_fire;
   logic [15:0] w_frame_nxt;
   logic [3:0]  w_nib;
   logic [3:0]  w_data_nxt;
   logic        w_last_nxt;
`ifdef FRAME_SER_PARITY_EN
   logic [3:0]  w_par;
`endif

   assign w_fire = r_out_valid & out_ready;

   // Next-state and next-output decode; outputs are registered from these.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_cap       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_cap       = 1'b1;
               w_beat_nxt  = 2'd0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_fire) begin
               if (r_beat == 2'd3) begin
`ifdef FRAME_SER_PARITY_EN
                  w_state_nxt = S_PAR;
`else
                  w_state_nxt = S_IDLE;
                  w_done      = 1'b1;
`endif
               end else begin
                  w_beat_nxt = r_beat + 2'd1;
               end
            end
         end
`ifdef FRAME_SER_PARITY_EN
         S_PAR: begin
            if (w_fire) begin
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase

      w_frame_nxt = w_cap ? 16'(frame) : r_frame;
      case (w_beat_nxt)
         2'd0:    w_nib = w_frame_nxt[15:12];
         2'd1:    w_nib = w_frame_nxt[11:8];
         2'd2:    w_nib = w_frame_nxt[7:4];
         default: w_nib = w_frame_nxt[3:0];
      endcase
`ifdef FRAME_SER_PARITY_EN
      w_par = w_frame_nxt[15:12] ^ w_frame_nxt[11:8] ^ w_frame_nxt[7:4] ^ w_frame_nxt[3:0];
`endif

      w_data_nxt = r_out_data;
      if (w_state_nxt == S_SHIFT) w_data_nxt = w_nib;
`ifdef FRAME_SER_PARITY_EN
      if (w_state_nxt == S_PAR)   w_data_nxt = w_par;
      w_last_nxt = (w_state_nxt == S_PAR);
`else
      w_last_nxt = (w_state_nxt == S_SHIFT) && (w_beat_nxt == 2'd3);
`endif
   end

   // State, capture and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_beat      <= 2'd0;
         r_frame     <= 16'd0;
         r_tag       <= 2'd0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 4'd0;
         r_out_last  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat      <= w_beat_nxt;
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt != S_IDLE);
         r_out_data  <= w_data_nxt;
         r_out_last  <= w_last_nxt;
         if (w_cap) begin
            r_frame <= w_frame_nxt;
            r_tag   <= 2'(tag);
         end
         if (w_done) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_tag;
   assign out_last  = r_out_last;
   assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: vector table for reset/basic frame, hand sequences for
// back-pressure, mid-frame reset and counter wrap (CNT_W=2). Honours FRAME_SER_PARITY_EN.
module tb_frame_serializer;
   localparam int unsigned CNT_W = 2;
`ifdef FRAME_SER_PARITY_EN
   localparam int NBEATS = 5;
`else
   localparam int NBEATS = 4;
`endif

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [15:0]      frame;
   logic [1:0]       tag, out_tag;
   logic [3:0]       out_data;
   logic [CNT_W-1:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   frame_serializer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .frame(frame), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic             rst, iv, ordy;
      logic [15:0]      frm;
      logic [1:0]       tg;
      logic             e_ir, e_ov;
      logic [3:0]       e_data;
      logic             e_last;
      logic [1:0]       e_tag;
      logic [CNT_W-1:0] e_cnt;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic e_ir, input logic e_ov, input logic [3:0] e_d,
                             input logic e_last, input logic [1:0] e_tag, input logic [CNT_W-1:0] e_cnt);
      chk({nm, ".in_ready"}, 16'(in_ready), 16'(e_ir));
      chk({nm, ".out_valid"}, 16'(out_valid), 16'(e_ov));
      if (e_ov) chk({nm, ".out_data"}, 16'(out_data), 16'(e_d));
      chk({nm, ".out_last"}, 16'(out_last), 16'(e_last));
      chk({nm, ".out_tag"}, 16'(out_tag), 16'(e_tag));
      chk({nm, ".frame_cnt"}, 16'(frame_cnt), 16'(e_cnt));
   endtask

   function automatic logic [3:0] beat_of(input logic [15:0] f, input int i);
      logic [15:0] s;
      if (i >= 4) return f[15:12] ^ f[11:8] ^ f[7:4] ^ f[3:0];
      s = f >> (12 - 4 * i);
      return s[3:0];
   endfunction

   function automatic void add(input logic r, input logic iv, input logic ordy, input logic [15:0] f,
                               input logic [1:0] t, input logic eir, input logic eov, input logic [3:0] ed,
                               input logic el, input logic [1:0] et, input logic [CNT_W-1:0] ec);
      vec_t v;
      v.rst = r; v.iv = iv; v.ordy = ordy; v.frm = f; v.tg = t;
      v.e_ir = eir; v.e_ov = eov; v.e_data = ed; v.e_last = el; v.e_tag = et; v.e_cnt = ec;
      vt.push_back(v);
   endfunction

   // Offer frame f/t with out_ready=1 and check every beat; hold_iv keeps in_valid high throughout
   // while the frame bus is scrambled during the beats.
   task automatic run_frame(input string nm, input logic [15:0] f, input logic [1:0] t, input logic hold_iv);
      frame = f; tag = t; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      if (!hold_iv) in_valid = 1'b0;
      frame = ~f; tag = ~t;
      for (int i = 0; i < NBEATS; i++) begin
         expect_out($sformatf("%s.beat%0d", nm, i), 1'b0, 1'b1, beat_of(f, i), (i == NBEATS - 1), t, exp_cnt);
         tick();
      end
      exp_cnt = exp_cnt + CNT_W'(1);
      expect_out({nm, ".idle"}, 1'b1, 1'b0, 4'd0, 1'b0, t, exp_cnt);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frame = 16'd0; tag = 2'd0;

      // Reset, release, then basic frame A53C / tag 10.
      add(1, 0, 0, 16'h0000, 2'b00, 0, 0, 4'h0, 0, 2'b00, 2'd0);
      add(1, 0, 0, 16'h0000, 2'b00, 0, 0, 4'h0, 0, 2'b00, 2'd0);
      add(1, 1, 1, 16'h1111, 2'b11, 0, 0, 4'h0, 0, 2'b00, 2'd0);
      add(0, 0, 1, 16'h0000, 2'b00, 1, 0, 4'h0, 0, 2'b00, 2'd0);
      add(0, 1, 1, 16'hA53C, 2'b10, 0, 1, 4'hA, 0, 2'b10, 2'd0);
      add(0, 0, 1, 16'h0000, 2'b00, 0, 1, 4'h5, 0, 2'b10, 2'd0);
      add(0, 0, 1, 16'h0000, 2'b00, 0, 1, 4'h3, 0, 2'b10, 2'd0);
`ifdef FRAME_SER_PARITY_EN
      add(0, 0, 1, 16'h0000, 2'b00, 0, 1, 4'hC, 0, 2'b10, 2'd0);
      add(0, 0, 1, 16'h0000, 2'b00, 0, 1, 4'h0, 1, 2'b10, 2'd0);
`else
      add(0, 0, 1, 16'h0000, 2'b00, 0, 1, 4'hC, 1, 2'b10, 2'd0);
`endif
      add(0, 0, 1, 16'h0000, 2'b00, 1, 0, 4'h0, 0, 2'b10, 2'd1);

      foreach (vt[k]) begin
         rst = vt[k].rst; in_valid = vt[k].iv; out_ready = vt[k].ordy;
         frame = vt[k].frm; tag = vt[k].tg;
         tick();
         expect_out($sformatf("vec%0d", k), vt[k].e_ir, vt[k].e_ov, vt[k].e_data,
                    vt[k].e_last, vt[k].e_tag, vt[k].e_cnt);
      end
      exp_cnt = 2'd1;
      in_valid = 1'b0;

      // Back-pressure on beat 1 for three cycles.
      frame = 16'h1234; tag = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      expect_out("bp.beat0", 0, 1, 4'h1, 0, 2'b01, exp_cnt);
      out_ready = 1'b1;
      tick();
      expect_out("bp.beat1", 0, 1, 4'h2, 0, 2'b01, exp_cnt);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("bp.hold%0d", i), 0, 1, 4'h2, 0, 2'b01, exp_cnt);
      end
      out_ready = 1'b1;
      for (int i = 2; i < NBEATS; i++) begin
         tick();
         expect_out($sformatf("bp.beat%0d", i), 0, 1, beat_of(16'h1234, i), (i == NBEATS - 1), 2'b01, exp_cnt);
      end
      tick();
      exp_cnt = exp_cnt + CNT_W'(1);
      expect_out("bp.idle", 1, 0, 4'h0, 0, 2'b01, exp_cnt);

      // Mid-frame reset after beat 1 accepted.
      frame = 16'h5A5A; tag = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      expect_out("mr.beat1", 0, 1, 4'hA, 0, 2'b11, exp_cnt);
      tick();
      rst = 1'b1;
      tick();
      exp_cnt = '0;
      expect_out("mr.rst", 0, 0, 4'h0, 0, 2'b00, exp_cnt);
      chk("mr.out_data_rst", 16'(out_data), 16'h0);
      rst = 1'b0;
      tick();
      expect_out("mr.release", 1, 0, 4'h0, 0, 2'b00, exp_cnt);
      run_frame("mr.ffff", 16'hFFFF, 2'b01, 1'b0);

      // Counter wrap with in_valid held high throughout.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      tick();
      expect_out("wrap.release", 1, 0, 4'h0, 0, 2'b00, exp_cnt);
      run_frame("wrap.f0", 16'h0123, 2'b00, 1'b1);
      run_frame("wrap.f1", 16'h4567, 2'b01, 1'b1);
      run_frame("wrap.f2", 16'h89AB, 2'b10, 1'b1);
      run_frame("wrap.f3", 16'hCDEF, 2'b11, 1'b1);
      run_frame("wrap.f4", 16'h3C96, 2'b01, 1'b1);
      chk("wrap.final_cnt", 16'(frame_cnt), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
